serial_subtractor: RTL and testbench

//   Bit-serial WIDTH-bit subtractor. It is the inverse-direction counterpart of the team's adder cells.
//   - Accepts operands a, b on a valid/ready handshake.
//   - Computes a - b LSB-first, one bit per clock, through a registered borrow.
//   - Presents diff and borrow on a valid/ready result handshake.
//   - Serves as the area-cheap subtract path in the arithmetic library.

---
 rtl/serial_arith_pkg.sv | 16 +
 rtl/serial_subtractor_fsub.sv | 39 +++
 rtl/serial_subtractor.sv | 89 ++++++++
 tb/tb_serial_subtractor.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
// rtl/serial_arith_pkg.sv - shared state encoding and sizing helpers for the serial arithmetic cells
package serial_arith_pkg;

  // Encoding is fixed so a future serial_adder can share it; 2'd3 is unused
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bit counter width: enough to index bits 0..width-1, never less than one bit
  function automatic int cnt_w(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_subtractor_fsub.sv
// rtl/serial_subtractor_fsub.sv - one-bit half and full subtractor cells
module half_subtractor (
  input  logic i_x,
  input  logic i_y,
  output logic o_d,
  output logic o_b
);
  assign o_d = i_x ^ i_y;
  assign o_b = ~i_x & i_y;
endmodule

module full_subtractor (
  input  logic i_x,
  input  logic i_y,
  input  logic i_bin,
  output logic o_d,
  output logic o_bout
);
  logic w_d1;
  logic w_b1;
  logic w_b2;

  half_subtractor u_hs_xy (
    .i_x (i_x),
    .i_y (i_y),
    .o_d (w_d1),
    .o_b (w_b1)
  );

  // Second stage subtracts the incoming borrow from the partial difference
  half_subtractor u_hs_bin (
    .i_x (w_d1),
    .i_y (i_bin),
    .o_d (o_d),
    .o_b (w_b2)
  );

  assign o_bout = w_b1 | w_b2;
endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a-b with registered borrow and valid/ready handshakes
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int            CW       = cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic [CW-1:0]    r_cnt;
  logic             w_d;
  logic             w_bout;
  logic             w_accept;

  assign start_ready = (r_state == IDLE);
  assign done_valid  = (r_state == DONE);
  assign diff        = r_diff;
  assign borrow      = r_borrow;
  assign w_accept    = start_valid && (r_state == IDLE);

  full_subtractor u_fsub (
    .i_x    (r_a_sh[0]),
    .i_y    (r_b_sh[0]),
    .i_bin  (r_borrow),
    .o_d    (w_d),
    .o_bout (w_bout)
  );

  // State register; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state: the last bit is processed on the same edge that enters DONE
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start_valid) w_next = SHIFT;
      SHIFT:   if (r_cnt == CNT_LAST) w_next = DONE;
      DONE:    if (done_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operand capture on accept, then one bit per cycle with differences entering at the MSB end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_a_sh   <= a;
      r_b_sh   <= b;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
    end else if (r_state == SHIFT) begin
      r_diff   <= {w_d, r_diff[WIDTH-1:1]};
      r_a_sh   <= r_a_sh >> 1;
      r_b_sh   <= r_b_sh >> 1;
      r_borrow <= w_bout;
      r_cnt    <= r_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor at WIDTH 8 and 2
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sv8, sr8, dv8, dr8, bw8;
  logic [7:0] a8, b8, d8;
  logic       sv2, sr2, dv2, dr2, bw2;
  logic [1:0] a2, b2, d2;
  int         checks = 0;
  int         fails  = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk (clk), .rst_n (rst_n),
    .start_valid (sv8), .start_ready (sr8), .a (a8), .b (b8),
    .done_valid (dv8), .done_ready (dr8), .diff (d8), .borrow (bw8)
  );

  serial_subtractor #(.WIDTH(2)) dut2 (
    .clk (clk), .rst_n (rst_n),
    .start_valid (sv2), .start_ready (sr2), .a (a2), .b (b2),
    .done_valid (dv2), .done_ready (dr2), .diff (d2), .borrow (bw2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer subtraction reduced modulo 2^w
  function automatic logic [31:0] ref_diff(input int x, input int y, input int w);
    int m;
    m = 1 << w;
    return 32'((x - y + m) % m);
  endfunction

  task automatic op8(input logic [7:0] xa, input logic [7:0] xb, output int lat);
    int n;
    n = 0;
    while (!sr8 && n < 50) begin tick(); n++; end
    a8 = xa; b8 = xb; sv8 = 1'b1;
    tick();
    sv8 = 1'b0;
    lat = 1;
    while (!dv8 && lat < 50) begin tick(); lat++; end
  endtask

  task automatic op2(input logic [1:0] xa, input logic [1:0] xb, output int lat);
    int n;
    n = 0;
    while (!sr2 && n < 50) begin tick(); n++; end
    a2 = xa; b2 = xb; sv2 = 1'b1;
    tick();
    sv2 = 1'b0;
    lat = 1;
    while (!dv2 && lat < 50) begin tick(); lat++; end
  endtask

  task automatic res8(input string tag, input int xa, input int xb);
    chk({tag, "_valid"}, 32'(dv8), 32'd1);
    chk({tag, "_diff"}, 32'(d8), ref_diff(xa, xb, 8));
    chk({tag, "_borrow"}, 32'(bw8), 32'(xa < xb));
  endtask

  task automatic release8();
    dr8 = 1'b1;
    tick();
    dr8 = 1'b0;
  endtask

  initial begin
    int lat;
    int last;
    int nres;
    int n;
    logic [7:0] hold_d;
    logic       hold_b;
    int ra, rb;

    rst_n = 1'b0;
    sv8 = 0; dr8 = 0; a8 = 0; b8 = 0;
    sv2 = 0; dr2 = 0; a2 = 0; b2 = 0;
    #12;
    chk("rst_start_ready", 32'(sr8), 32'd1);
    chk("rst_done_valid", 32'(dv8), 32'd0);
    chk("rst_diff", 32'(d8), 32'd0);
    chk("rst_borrow", 32'(bw8), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Basic subtraction and latency
    op8(8'd200, 8'd55, lat);
    chk("t1_latency", 32'(lat), 32'd9);
    res8("t1", 200, 55);
    release8();

    op8(8'd5, 8'd9, lat);
    res8("t2_wrap", 5, 9);
    release8();
    op8(8'hA5, 8'hA5, lat);
    res8("t2_equal", 165, 165);
    release8();

    // Result held stable while the consumer stalls
    op8(8'd77, 8'd100, lat);
    res8("t3", 77, 100);
    hold_d = d8;
    hold_b = bw8;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_hold_valid", 32'(dv8), 32'd1);
      chk("t3_hold_diff", 32'(d8), 32'(hold_d));
      chk("t3_hold_borrow", 32'(bw8), 32'(hold_b));
    end
    release8();
    chk("t3_idle_ready", 32'(sr8), 32'd1);
    chk("t3_idle_valid", 32'(dv8), 32'd0);

    // start_valid held with different operands while busy must not recapture
    a8 = 8'd30; b8 = 8'd12; sv8 = 1'b1;
    tick();
    a8 = 8'd250; b8 = 8'd3;
    n = 0;
    while (!dv8 && n < 50) begin tick(); n++; end
    sv8 = 1'b0;
    res8("t4", 30, 12);
    release8();

    // Asynchronous reset in the middle of SHIFT
    a8 = 8'd9; b8 = 8'd4; sv8 = 1'b1;
    tick();
    sv8 = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("t5_rst_ready", 32'(sr8), 32'd1);
    chk("t5_rst_valid", 32'(dv8), 32'd0);
    chk("t5_rst_diff", 32'(d8), 32'd0);
    chk("t5_rst_borrow", 32'(bw8), 32'd0);
    tick();
    chk("t5_rst_no_result", 32'(dv8), 32'd0);
    rst_n = 1'b1;
    tick();
    op8(8'd123, 8'd200, lat);
    chk("t5_latency", 32'(lat), 32'd9);
    res8("t5_after", 123, 200);
    release8();

    // Back-to-back with both handshake inputs tied high
    a8 = 8'd150; b8 = 8'd160; sv8 = 1'b1; dr8 = 1'b1;
    last = -1;
    nres = 0;
    for (int c = 0; c < 45; c++) begin
      tick();
      if (dv8) begin
        nres++;
        chk("t6_diff", 32'(d8), ref_diff(150, 160, 8));
        chk("t6_borrow", 32'(bw8), 32'd1);
        if (last >= 0) chk("t6_period", 32'(c - last), 32'd10);
        last = c;
      end
    end
    chk("t6_result_count", 32'(nres), 32'd4);
    sv8 = 1'b0;
    n = 0;
    while (!(sr8 && !dv8) && n < 30) begin tick(); n++; end
    dr8 = 1'b0;
    chk("t6_drained", 32'(sr8), 32'd1);

    // Random sweep, WIDTH=8
    for (int i = 0; i < 1000; i++) begin
      ra = int'($urandom_range(0, 255));
      rb = int'($urandom_range(0, 255));
      op8(8'(ra), 8'(rb), lat);
      if (lat != 9) chk("r8_latency", 32'(lat), 32'd9);
      res8("r8", ra, rb);
      release8();
    end

    // Random sweep, WIDTH=2
    for (int i = 0; i < 1000; i++) begin
      ra = int'($urandom_range(0, 3));
      rb = int'($urandom_range(0, 3));
      op2(2'(ra), 2'(rb), lat);
      if (lat != 3) chk("r2_latency", 32'(lat), 32'd3);
      chk("r2_valid", 32'(dv2), 32'd1);
      chk("r2_diff", 32'(d2), ref_diff(ra, rb, 2));
      chk("r2_borrow", 32'(bw2), 32'(ra < rb));
      dr2 = 1'b1;
      tick();
      dr2 = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
